kmac_msg_fifo: RTL and testbench

KMAC_MSG_FIFO -- requirements
Module: kmac_msg_fifo

---
 rtl/kmac_msg_fifo.sv | 184 ++++++++++++++++++
 tb/tb_kmac_msg_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmac_msg_fifo.sv
// rtl/kmac_msg_fifo.sv - message word packer feeding a registered-output beat FIFO
//
// Packs InW-bit message words (optionally byte-swapped) into OutW-bit beats,
// LSB word first, and queues completed beats in a Depth-entry FIFO.
//
// Optional feature macro: KMAC_MSG_FIFO_STRB_CHECK_EN
//   defined   : err_o pulses one cycle after an accepted word breaks the strobe rule
//   undefined : err_o tied low, no checker logic
//
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   clear_i                     synchronous flush of packer and FIFO
//   swap_i                      byte-reverse the accepted word and its strobe
//   in_valid_i / in_ready_o     input word handshake
//   in_data_i, in_strb_i        message word and byte enables
//   in_last_i                   final word of message
//   out_valid_o / out_ready_i   output beat handshake
//   out_data_o, out_strb_o      packed beat and byte enables
//   out_last_o                  final beat of message
//   depth_o                     occupied FIFO entries
//   err_o                       strobe-rule violation pulse

module kmac_msg_fifo #(
    parameter  int InW    = 32,
    parameter  int OutW   = 64,
    parameter  int Depth  = 10,
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                swap_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [InW-1:0]      in_data_i,
    input  logic [InW/8-1:0]    in_strb_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OutW-1:0]     out_data_o,
    output logic [OutW/8-1:0]   out_strb_o,
    output logic                out_last_o,
    output logic [DepthW-1:0]   depth_o,
    output logic                err_o
);

    localparam int R    = OutW / InW;
    localparam int InB  = InW / 8;
    localparam int OutB = OutW / 8;
    localparam int CntW = (R > 1) ? $clog2(R) : 1;
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int EntW = 1 + OutB + OutW;

    localparam logic [CntW-1:0]   LastSlot = CntW'(R - 1);
    localparam logic [PtrW-1:0]   LastPtr  = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] FullCnt  = DepthW'(Depth);

    // Packer state
    logic [CntW-1:0] cnt;
    logic [OutW-1:0] pack_data;
    logic [OutB-1:0] pack_strb;

    // FIFO state
    logic [EntW-1:0]   mem [Depth];
    logic [PtrW-1:0]   wptr;
    logic [PtrW-1:0]   rptr;
    logic [DepthW-1:0] count;

    logic [InW-1:0]  word_data;
    logic [InB-1:0]  word_strb;
    logic [OutW-1:0] beat_data;
    logic [OutB-1:0] beat_strb;
    logic            empty_msg;
    logic            beat_done;
    logic            accept;
    logic            push;
    logic            pop;

    assign in_ready_o = rst_ni && !clear_i && (count < FullCnt);
    assign accept     = in_valid_i && in_ready_o;
    assign beat_done  = in_last_i || (cnt == LastSlot);
    assign push       = accept && beat_done;
    assign pop        = out_valid_o && out_ready_i;

    // An empty message (last word, no strobes, nothing packed yet) becomes an
    // all-zero beat regardless of what the data lines carry.
    assign empty_msg = in_last_i && (in_strb_i == '0) && (cnt == '0);

    always_comb begin
        word_data = '0;
        word_strb = '0;
        for (int i = 0; i < InB; i++) begin
            word_data[i*8 +: 8] = swap_i ? in_data_i[(InB-1-i)*8 +: 8] : in_data_i[i*8 +: 8];
            word_strb[i]        = swap_i ? in_strb_i[InB-1-i]         : in_strb_i[i];
        end
        if (empty_msg) begin
            word_data = '0;
        end
    end

    // Slots above cnt are already zero in pack_*, so a last word leaves the
    // unused tail of the beat cleared.
    always_comb begin
        beat_data = pack_data;
        beat_strb = pack_strb;
        for (int k = 0; k < R; k++) begin
            if (cnt == CntW'(k)) begin
                beat_data[k*InW +: InW] = word_data;
                beat_strb[k*InB +: InB] = word_strb;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            cnt       <= '0;
            pack_data <= '0;
            pack_strb <= '0;
        end else if (accept) begin
            if (beat_done) begin
                cnt       <= '0;
                pack_data <= '0;
                pack_strb <= '0;
            end else begin
                cnt       <= cnt + 1'b1;
                pack_data <= beat_data;
                pack_strb <= beat_strb;
            end
        end
    end

    // Storage needs no reset: push is gated by in_ready_o, and outputs are
    // masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= {in_last_i, beat_strb, beat_data};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid_o = (count != '0);
    assign depth_o     = count;
    assign {out_last_o, out_strb_o, out_data_o} = out_valid_o ? mem[rptr] : '0;

`ifdef KMAC_MSG_FIFO_STRB_CHECK_EN
    logic strb_contig;
    logic err_q;

    // LSB-contiguous strobes look like 0..01..1; adding one clears every set bit.
    assign strb_contig = ((in_strb_i & (in_strb_i + 1'b1)) == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (in_last_i ? !strb_contig : (in_strb_i != '1));
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_kmac_msg_fifo.sv
// tb/tb_kmac_msg_fifo.sv - self-checking bench for kmac_msg_fifo
module tb_kmac_msg_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        swap;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_strb;
    logic        out_last;
    logic [3:0]  depth;
    logic        err;

    always #5 clk = ~clk;

    kmac_msg_fifo dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .swap_i      (swap),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_strb_i   (in_strb),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .out_last_o  (out_last),
        .depth_o     (depth),
        .err_o       (err)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] m_data;
    logic [7:0]  m_strb;
    int          m_k;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] srev(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    function automatic logic exp_err(input logic [3:0] s, input logic l);
`ifdef KMAC_MSG_FIFO_STRB_CHECK_EN
        if (l) return !(s inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF});
        return s != 4'hF;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_data = '0;
        m_strb = '0;
        m_k    = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic [3:0] s, input logic l, input logic sw);
        logic [31:0] w;
        logic [3:0]  st;
        beat_t       b;
        w  = sw ? bswap(d) : d;
        st = sw ? srev(s) : s;
        if (l && s == 4'h0 && m_k == 0) w = '0;
        m_data = m_data | ({32'h0, w} << (32 * m_k));
        m_strb = m_strb | ({4'h0, st} << (4 * m_k));
        if (l || m_k == 1) begin
            b.d = m_data;
            b.s = m_strb;
            b.l = l;
            exp_q.push_back(b);
            m_data = '0;
            m_strb = '0;
            m_k    = 0;
        end else begin
            m_k = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends 1 time unit after a rising edge; leaves one idle cycle.
    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l, input logic sw);
        int waited;
        in_data  = d;
        in_strb  = s;
        in_last  = l;
        swap     = sw;
        in_valid = 1'b1;
        waited   = 0;
        #4;
        while (!in_ready && waited < 50) begin
            tick();
            #4;
            waited++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        model_accept(d, s, l, sw);
        tick();
        in_valid = 1'b0;
        #4;
        chk("err_after_word", err, exp_err(s, l));
        tick();
    endtask

    task automatic pop_check(input string tag);
        int    waited;
        beat_t b;
        out_ready = 1'b1;
        waited    = 0;
        #4;
        while (!out_valid && waited < 50) begin
            tick();
            #4;
            waited++;
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk({tag, "_data"}, out_data, b.d);
            chk({tag, "_strb"}, out_strb, b.s);
            chk({tag, "_last"}, out_last, b.l);
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] contig [5];
        logic [3:0] rs;
        logic       rl;
        logic       err_exp;
        beat_t      b;

        contig    = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
        rst_n     = 1'b0;
        clear     = 1'b0;
        swap      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_strb   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        // Reset state
        tick();
        tick();
        #4;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_depth", depth, 4'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_strb", out_strb, 8'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err", err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two words, no swap; beat visible the cycle after the last word
        in_data = 32'h03020100; in_strb = 4'hF; in_last = 1'b0; swap = 1'b0; in_valid = 1'b1;
        model_accept(32'h03020100, 4'hF, 1'b0, 1'b0);
        tick();
        in_data = 32'h07060504; in_last = 1'b1;
        model_accept(32'h07060504, 4'hF, 1'b1, 1'b0);
        #4;
        chk("two_word_depth_before", depth, 4'd0);
        tick();
        in_valid = 1'b0;
        #4;
        chk("two_word_depth", depth, 4'd1);
        chk("two_word_const_data", out_data, 64'h0706050403020100);
        tick();
        pop_check("two_word");

        // Same words byte-swapped
        send_word(32'h03020100, 4'hF, 1'b0, 1'b1);
        send_word(32'h07060504, 4'hF, 1'b1, 1'b1);
        #4;
        chk("swap_const_data", out_data, 64'h0405060700010203);
        tick();
        pop_check("swap");

        // Single partial word with last
        send_word(32'hAABBCCDD, 4'h3, 1'b1, 1'b0);
        #4;
        chk("single_const_strb", out_strb, 8'h03);
        tick();
        pop_check("single");

        // Empty message
        send_word(32'h12345678, 4'h0, 1'b1, 1'b0);
        pop_check("empty");

        // Non-contiguous strobe on last word
        send_word(32'h11223344, 4'h5, 1'b1, 1'b0);
        #4;
        chk("err_pulse_end", err, 1'b0);
        tick();
        pop_check("bad_strb");

        // Fill to Depth with output stalled
        for (int i = 0; i < 20; i++) begin
            send_word($urandom, 4'hF, 1'b0, 1'($urandom_range(0, 1)));
        end
        #4;
        chk("full_depth", depth, 4'd10);
        chk("full_in_ready", in_ready, 1'b0);
        tick();
        pop_check("full_pop");
        #4;
        chk("after_pop_depth", depth, 4'd9);
        chk("after_pop_in_ready", in_ready, 1'b1);
        tick();
        send_word(32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
        // Complete a beat in the same cycle as a pop
        in_data = 32'hDEADBEEF; in_strb = 4'hF; in_last = 1'b0; swap = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #4;
        chk("pushpop_in_ready", in_ready, 1'b1);
        b = exp_q.pop_front();
        chk("pushpop_pop_data", out_data, b.d);
        model_accept(32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #4;
        chk("pushpop_depth", depth, 4'd9);
        tick();
        while (exp_q.size() > 0) pop_check("drain");

        // Clear in mid-beat with a beat already queued
        send_word(32'h01010101, 4'hF, 1'b0, 1'b0);
        send_word(32'h02020202, 4'hF, 1'b0, 1'b0);
        send_word(32'h03030303, 4'hF, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        #4;
        chk("clear_depth", depth, 4'd0);
        chk("clear_out_valid", out_valid, 1'b0);
        tick();
        send_word(32'h0A0B0C0D, 4'hF, 1'b0, 1'b0);
        send_word(32'h01020304, 4'hF, 1'b1, 1'b0);
        pop_check("after_clear");

        // Reset mid-message
        send_word(32'h55555555, 4'hF, 1'b0, 1'b0);
        send_word(32'h66666666, 4'hF, 1'b0, 1'b0);
        send_word(32'h77777777, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        #4;
        chk("midrst_depth", depth, 4'd0);
        tick();
        send_word(32'h88888888, 4'h1, 1'b1, 1'b0);
        pop_check("after_midrst");

        // Randomized traffic against the model
        err_exp = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rl = ($urandom_range(0, 3) == 0);
            if (rl) rs = ($urandom_range(0, 5) == 5) ? 4'($urandom) : contig[$urandom_range(0, 4)];
            else    rs = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            in_data   = $urandom;
            in_strb   = rs;
            in_last   = rl;
            swap      = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            #4;
            chk("rnd_depth", depth, 64'(exp_q.size()));
            chk("rnd_in_ready", in_ready, exp_q.size() < 10);
            chk("rnd_out_valid", out_valid, exp_q.size() != 0);
            chk("rnd_err", err, err_exp);
            err_exp = 1'b0;
            if (in_valid && exp_q.size() < 10) begin
                err_exp = exp_err(rs, rl);
                if (out_ready && exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk("rnd_data", out_data, b.d);
                    chk("rnd_strb", out_strb, b.s);
                    chk("rnd_last", out_last, b.l);
                end
                model_accept(in_data, rs, rl, swap);
            end else if (out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("rnd_data", out_data, b.d);
                chk("rnd_strb", out_strb, b.s);
                chk("rnd_last", out_last, b.l);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        while (exp_q.size() > 0) pop_check("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
